// File: rtl/regs_wb_arbiter_if.sv
// Writeback bundle: ALU and load-unit requests into the arbiter, register-file write port out.
interface regs_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            i_alu_valid;
    logic [AW-1:0]   i_alu_rd;
    logic [XLEN-1:0] i_alu_data;
    logic            o_alu_ready;

    logic            i_ld_valid;
    logic [AW-1:0]   i_ld_rd;
    logic [XLEN-1:0] i_ld_data;
    logic            o_ld_ready;

    logic            o_wr_en;
    logic [AW-1:0]   o_wr_addr;
    logic [XLEN-1:0] o_wr_data;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        input  o_alu_ready,
        output i_ld_valid, i_ld_rd, i_ld_data,
        input  o_ld_ready,
        input  o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        output o_alu_ready,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        output o_ld_ready,
        output o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter with a load scoreboard driving the decode stall.
// Optional REGS_WB_BYPASS_EN adds a forward path from the committing load write.
module regs_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    regs_wb_arbiter_if.slave      wb,
    input  logic                  i_ld_issue,
    input  logic [AW-1:0]         i_ld_issue_rd,
    input  logic [AW-1:0]         i_rs1_addr,
    input  logic [AW-1:0]         i_rs2_addr,
    input  logic [AW-1:0]         i_rd_addr,
    output logic                  o_stall,
    output logic                  o_sb_overflow
`ifdef REGS_WB_BYPASS_EN
    ,
    output logic                  o_fwd1_en,
    output logic                  o_fwd2_en,
    output logic [XLEN-1:0]       o_fwd_data
`endif
);

    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            wr_is_ld_q, wr_is_ld_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            overflow_q, overflow_d;

    logic alu_starved;
    logic alu_grant;
    logic ld_grant;
    logic issue_live;
    logic ld_commit;
    logic rs1_pend, rs2_pend, rd_pend;
    logic issue_hit;
    logic fwd1, fwd2;

    // Loads win ties so pipelined loads drain fast, but a waiting ALU result is never starved beyond MAX_WAIT.
    always_comb begin
        alu_starved = (starve_cnt_q == STARVE_MAX);
        alu_grant   = clk_en & wb.i_alu_valid & (~wb.i_ld_valid | alu_starved);
        ld_grant    = clk_en & wb.i_ld_valid & ~alu_grant;
        issue_live  = i_ld_issue & (i_ld_issue_rd != '0);
        ld_commit   = wr_en_q & wr_is_ld_q;
    end

    assign wb.o_alu_ready = alu_grant;
    assign wb.o_ld_ready  = ld_grant;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_is_ld_d   = wr_is_ld_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;

        if (clk_en) begin
            if (alu_grant) begin
                starve_cnt_d = '0;
            end else if (wb.i_alu_valid && !alu_starved) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end

            wr_en_d    = 1'b0;
            wr_is_ld_d = 1'b0;
            if (alu_grant) begin
                wr_addr_d = wb.i_alu_rd;
                wr_data_d = wb.i_alu_data;
                wr_en_d   = (wb.i_alu_rd != '0);
            end else if (ld_grant) begin
                wr_addr_d  = wb.i_ld_rd;
                wr_data_d  = wb.i_ld_data;
                wr_en_d    = (wb.i_ld_rd != '0);
                wr_is_ld_d = 1'b1;
            end

            // Clear is applied before set so a same-cycle re-issue keeps the register pending.
            if (ld_commit) begin
                pending_d[wr_addr_q] = 1'b0;
            end
            if (issue_live) begin
                if (pending_q[i_ld_issue_rd]) begin
                    overflow_d = 1'b1;
                end
                pending_d[i_ld_issue_rd] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_is_ld_q   <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_is_ld_q   <= wr_is_ld_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wb.o_wr_en     = wr_en_q;
    assign wb.o_wr_addr   = wr_addr_q;
    assign wb.o_wr_data   = wr_data_q;
    assign o_sb_overflow  = overflow_q;

    // A load issued this cycle already blocks its consumers, before the scoreboard bit is visible.
    always_comb begin
        rs1_pend  = (i_rs1_addr != '0) & pending_q[i_rs1_addr];
        rs2_pend  = (i_rs2_addr != '0) & pending_q[i_rs2_addr];
        rd_pend   = (i_rd_addr  != '0) & pending_q[i_rd_addr];
        issue_hit = issue_live & ((i_ld_issue_rd == i_rs1_addr) |
                                  (i_ld_issue_rd == i_rs2_addr) |
                                  (i_ld_issue_rd == i_rd_addr));
`ifdef REGS_WB_BYPASS_EN
        fwd1 = ld_commit & (wr_addr_q == i_rs1_addr) & rs1_pend;
        fwd2 = ld_commit & (wr_addr_q == i_rs2_addr) & rs2_pend;
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        o_stall = (rs1_pend & ~fwd1) | (rs2_pend & ~fwd2) | rd_pend | issue_hit;
    end

`ifdef REGS_WB_BYPASS_EN
    assign o_fwd1_en  = fwd1;
    assign o_fwd2_en  = fwd2;
    assign o_fwd_data = wr_data_q;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: expected register-file writes are queued at grant time
// and popped one cycle later; comb outputs are checked with immediate assertions.
module tb_regs_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic            en;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            i_ld_issue;
    logic [AW-1:0]   i_ld_issue_rd;
    logic [AW-1:0]   i_rs1_addr;
    logic [AW-1:0]   i_rs2_addr;
    logic [AW-1:0]   i_rd_addr;
    logic            o_stall;
    logic            o_sb_overflow;
`ifdef REGS_WB_BYPASS_EN
    logic            o_fwd1_en;
    logic            o_fwd2_en;
    logic [XLEN-1:0] o_fwd_data;
`endif

    int  checks = 0;
    int  errors = 0;
    int  starve_model = 0;
    wr_t sb_q[$];

    regs_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regs_wb_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .wb            (bus),
        .i_ld_issue    (i_ld_issue),
        .i_ld_issue_rd (i_ld_issue_rd),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_rd_addr     (i_rd_addr),
        .o_stall       (o_stall),
        .o_sb_overflow (o_sb_overflow)
`ifdef REGS_WB_BYPASS_EN
        ,
        .o_fwd1_en     (o_fwd1_en),
        .o_fwd2_en     (o_fwd2_en),
        .o_fwd_data    (o_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adata,
                                 input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldata);
        bus.i_alu_valid = av;
        bus.i_alu_rd    = ard;
        bus.i_alu_data  = adata;
        bus.i_ld_valid  = lv;
        bus.i_ld_rd     = lrd;
        bus.i_ld_data   = ldata;
        #1;
    endtask

    task automatic setDecode(input logic issue, input logic [AW-1:0] issue_rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
        i_ld_issue    = issue;
        i_ld_issue_rd = issue_rd;
        i_rs1_addr    = rs1;
        i_rs2_addr    = rs2;
        i_rd_addr     = rd;
    endtask

    task automatic expectGrant(input string tag, input bit exp_alu, input bit exp_ld);
        wr_t e;
        checkOutput({tag, "_alu_ready"}, 32'(bus.o_alu_ready), 32'(exp_alu));
        checkOutput({tag, "_ld_ready"},  32'(bus.o_ld_ready),  32'(exp_ld));
        e = '0;
        if (exp_alu) begin
            e.en   = (bus.i_alu_rd != '0);
            e.addr = bus.i_alu_rd;
            e.data = bus.i_alu_data;
        end else if (exp_ld) begin
            e.en   = (bus.i_ld_rd != '0);
            e.addr = bus.i_ld_rd;
            e.data = bus.i_ld_data;
        end
        sb_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_wr_en"}, 32'(bus.o_wr_en), 32'(e.en));
            if (e.en) begin
                checkOutput({tag, "_wr_addr"}, 32'(bus.o_wr_addr), 32'(e.addr));
                checkOutput({tag, "_wr_data"}, bus.o_wr_data, e.data);
            end
        end
    endtask

    initial begin
        bit exp_alu;
        rst    = 1'b1;
        clk_en = 1'b1;
        setDecode(1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        setDecode(1'b0, '0, 5'd5, '0, '0);
        #1;
        checkOutput("reset_wr_en",    32'(bus.o_wr_en),   32'd0);
        checkOutput("reset_wr_addr",  32'(bus.o_wr_addr), 32'd0);
        checkOutput("reset_wr_data",  bus.o_wr_data,      32'd0);
        checkOutput("reset_overflow", 32'(o_sb_overflow), 32'd0);
        checkOutput("reset_stall",    32'(o_stall),       32'd0);

        $display("[TB] ALU-only writeback");
        setDecode(1'b0, '0, '0, '0, '0);
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
        expectGrant("alu_only", 1'b1, 1'b0);
        tick("alu_only");
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("alu_idle", 1'b0, 1'b0);
        tick("alu_idle");

        $display("[TB] load priority and ALU starvation limit");
        starve_model = 0;
        for (int i = 0; i < 5; i++) begin
            exp_alu = (starve_model == MAX_WAIT);
            applyStimulus(1'b1, 5'd3, 32'hA0, 1'b1, 5'(10 + i), 32'(32'h100 + i));
            expectGrant("starve", exp_alu, !exp_alu);
            if (exp_alu) starve_model = 0;
            else         starve_model++;
            tick("starve");
        end
        applyStimulus(1'b1, 5'd4, 32'hB0, 1'b1, 5'd20, 32'h200);
        expectGrant("starve_reset_ld", 1'b0, 1'b1);
        tick("starve_reset_ld");
        applyStimulus(1'b1, 5'd4, 32'hB0, 1'b0, '0, '0);
        expectGrant("starve_drain_alu", 1'b1, 1'b0);
        tick("starve_drain_alu");

        $display("[TB] load-use hazard on x7");
        setDecode(1'b1, 5'd7, 5'd7, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("haz_issue_stall", 32'(o_stall), 32'd1);
        expectGrant("haz_issue", 1'b0, 1'b0);
        tick("haz_issue");
        setDecode(1'b0, '0, 5'd7, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("haz_pending_stall", 32'(o_stall), 32'd1);
        expectGrant("haz_wait", 1'b0, 1'b0);
        tick("haz_wait");
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        checkOutput("haz_load_stall", 32'(o_stall), 32'd1);
        expectGrant("haz_load", 1'b0, 1'b1);
        tick("haz_load");
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef REGS_WB_BYPASS_EN
        checkOutput("haz_commit_stall", 32'(o_stall),   32'd0);
        checkOutput("haz_fwd1_en",      32'(o_fwd1_en), 32'd1);
        checkOutput("haz_fwd2_en",      32'(o_fwd2_en), 32'd0);
        checkOutput("haz_fwd_data",     o_fwd_data,     32'hDEAD_BEEF);
`else
        checkOutput("haz_commit_stall", 32'(o_stall), 32'd1);
`endif
        expectGrant("haz_commit", 1'b0, 1'b0);
        tick("haz_commit");
        checkOutput("haz_after_stall", 32'(o_stall),       32'd0);
        checkOutput("haz_overflow",    32'(o_sb_overflow), 32'd0);

        $display("[TB] x0 destination");
        setDecode(1'b1, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 32'h55);
        checkOutput("x0_stall", 32'(o_stall), 32'd0);
        expectGrant("x0_load", 1'b0, 1'b1);
        tick("x0_load");
        setDecode(1'b0, '0, '0, '0, '0);
        #1;
        checkOutput("x0_after_stall", 32'(o_stall), 32'd0);

        $display("[TB] same-cycle set and clear on x9, then re-issue");
        setDecode(1'b1, 5'd9, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("sc_issue", 1'b0, 1'b0);
        tick("sc_issue");
        setDecode(1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        expectGrant("sc_load", 1'b0, 1'b1);
        tick("sc_load");
        setDecode(1'b1, 5'd9, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("sc_setclr", 1'b0, 1'b0);
        tick("sc_setclr");
        setDecode(1'b0, '0, 5'd9, '0, '0);
        #1;
        checkOutput("sc_still_pending", 32'(o_stall), 32'd1);
        setDecode(1'b1, 5'd9, 5'd9, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("sc_reissue", 1'b0, 1'b0);
        tick("sc_reissue");
        checkOutput("sc_overflow", 32'(o_sb_overflow), 32'd1);
        setDecode(1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("sc_sticky", 1'b0, 1'b0);
        tick("sc_sticky");
        checkOutput("sc_overflow_sticky", 32'(o_sb_overflow), 32'd1);

        $display("[TB] clock enable low freezes state");
        applyStimulus(1'b1, 5'd12, 32'hC0, 1'b0, '0, '0);
        expectGrant("ce_prime", 1'b1, 1'b0);
        tick("ce_prime");
        clk_en = 1'b0;
        setDecode(1'b1, 5'd14, '0, '0, '0);
        applyStimulus(1'b1, 5'd20, 32'hE0, 1'b1, 5'd21, 32'hE1);
        checkOutput("ce_alu_ready", 32'(bus.o_alu_ready), 32'd0);
        checkOutput("ce_ld_ready",  32'(bus.o_ld_ready),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("ce_hold_wr_en",   32'(bus.o_wr_en),   32'd1);
        checkOutput("ce_hold_wr_addr", 32'(bus.o_wr_addr), 32'd12);
        checkOutput("ce_hold_wr_data", bus.o_wr_data,      32'hC0);
        setDecode(1'b0, '0, 5'd14, '0, '0);
        #1;
        checkOutput("ce_no_pending", 32'(o_stall), 32'd0);
        clk_en = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("ce_resume", 1'b0, 1'b0);
        tick("ce_resume");

        $display("[TB] reset during an in-flight write");
        setDecode(1'b1, 5'd15, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectGrant("rst_issue", 1'b0, 1'b0);
        tick("rst_issue");
        setDecode(1'b0, '0, 5'd15, '0, '0);
        applyStimulus(1'b1, 5'd16, 32'h16, 1'b0, '0, '0);
        checkOutput("rst_pre_stall", 32'(o_stall), 32'd1);
        expectGrant("rst_write", 1'b1, 1'b0);
        tick("rst_write");
        rst = 1'b1;
        applyStimulus(1'b1, 5'd17, 32'h17, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("rst_wr_en",    32'(bus.o_wr_en),   32'd0);
        checkOutput("rst_wr_addr",  32'(bus.o_wr_addr), 32'd0);
        checkOutput("rst_stall",    32'(o_stall),       32'd0);
        checkOutput("rst_overflow", 32'(o_sb_overflow), 32'd0);

        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
